// File: rtl/multi_peak_finder.sv
// Per-channel region peak finder for FBG spectra: one frame in, a MAX_PEAKS-word burst of
// peak indices out. Unused slots hold the all-ones sentinel.
//
// state | meaning
// IDLE  | wait for run_stb_i, outputs quiet
// ACQ   | consume SAMPLES valid samples, track open regions, commit closed ones
// FLUSH | one cycle: commit regions still open at end of frame, load first word
// OUT   | MAX_PEAKS strobed words, slot k in cycle k
module multi_peak_finder #(
  parameter int CH        = 4,
  parameter int DW        = 24,
  parameter int IW        = 14,
  parameter int SAMPLES   = 8192,
  parameter int MAX_PEAKS = 16,
  localparam int PW       = $clog2(MAX_PEAKS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_stb_i,
  input  logic             valid_i,
  input  logic [DW-1:0]    thr_i,
  input  logic [CH*DW-1:0] data_i,
  output logic             busy_o,
  output logic             rdy_stb_o,
  output logic [CH*IW-1:0] data_o,
  output logic [CH*PW-1:0] cnt_o,
  output logic [CH-1:0]    ovf_o
);

  localparam int KW = (MAX_PEAKS > 1) ? $clog2(MAX_PEAKS) : 1;
  localparam logic [IW-1:0] SENT   = {IW{1'b1}};
  localparam logic [IW-1:0] LAST_N = IW'(SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, ACQ, FLUSH, OUT} state_t;

  state_t          state;
  logic [DW-1:0]   thr_q;
  logic [IW-1:0]   n;
  logic [KW-1:0]   out_k;
  logic [CH-1:0]   open;
  logic [CH-1:0]   ovf;
  logic [DW-1:0]   pk_max [CH];
  logic [IW-1:0]   pk_idx [CH];
  logic [PW-1:0]   cnt    [CH];
  logic [IW-1:0]   slot   [CH][MAX_PEAKS];

  logic [DW-1:0]   x      [CH];
  logic [CH-1:0]   above;
  logic [CH-1:0]   room;
  logic [CH-1:0]   commit;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      x[c]      = data_i[c*DW +: DW];
      above[c]  = x[c] > thr_q;
      room[c]   = cnt[c] < PW'(MAX_PEAKS);
      commit[c] = open[c] && ((state == ACQ && valid_i && !above[c]) || state == FLUSH);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      thr_q     <= '0;
      n         <= '0;
      out_k     <= '0;
      open      <= '0;
      ovf       <= '0;
      busy_o    <= 1'b0;
      rdy_stb_o <= 1'b0;
      data_o    <= '0;
      cnt_o     <= '0;
      ovf_o     <= '0;
      for (int c = 0; c < CH; c++) begin
        pk_max[c] <= '0;
        pk_idx[c] <= '0;
        cnt[c]    <= '0;
        for (int k = 0; k < MAX_PEAKS; k++) slot[c][k] <= SENT;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (commit[c]) begin
          if (room[c]) begin
            slot[c][cnt[c][KW-1:0]] <= pk_idx[c];
            cnt[c] <= cnt[c] + 1'b1;
          end else begin
            ovf[c] <= 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (run_stb_i) begin
            thr_q  <= thr_i;
            n      <= '0;
            open   <= '0;
            ovf    <= '0;
            ovf_o  <= '0;
            busy_o <= 1'b1;
            state  <= ACQ;
            for (int c = 0; c < CH; c++) begin
              cnt[c] <= '0;
              for (int k = 0; k < MAX_PEAKS; k++) slot[c][k] <= SENT;
            end
          end
        end

        ACQ: begin
          if (valid_i) begin
            n <= n + 1'b1;
            for (int c = 0; c < CH; c++) begin
              if (!open[c]) begin
                if (above[c]) begin
                  open[c]   <= 1'b1;
                  pk_max[c] <= x[c];
                  pk_idx[c] <= n;
                end
              end else if (!above[c]) begin
                open[c] <= 1'b0;
              end else if (x[c] > pk_max[c]) begin
                pk_max[c] <= x[c];
                pk_idx[c] <= n;
              end
            end
            if (n == LAST_N) state <= FLUSH;
          end
        end

        FLUSH: begin
          open      <= '0;
          out_k     <= '0;
          rdy_stb_o <= 1'b1;
          state     <= OUT;
          // Slot 0 may be written by this very cycle's commit, so forward it.
          for (int c = 0; c < CH; c++) begin
            data_o[c*IW +: IW] <= (commit[c] && cnt[c] == '0) ? pk_idx[c] : slot[c][0];
            cnt_o[c*PW +: PW]  <= cnt[c] + PW'(commit[c] & room[c]);
            ovf_o[c]           <= ovf[c] | (commit[c] & ~room[c]);
          end
        end

        OUT: begin
          if (out_k == KW'(MAX_PEAKS - 1)) begin
            rdy_stb_o <= 1'b0;
            busy_o    <= 1'b0;
            data_o    <= '0;
            cnt_o     <= '0;
            state     <= IDLE;
          end else begin
            out_k <= out_k + 1'b1;
            for (int c = 0; c < CH; c++) data_o[c*IW +: IW] <= slot[c][out_k + 1'b1];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_peak_finder.sv
// Directed bench for multi_peak_finder: per-frame stimulus and expected-result tables,
// plus hand sequences for latency, ignored strobes and reset abort.
module tb_multi_peak_finder;
  localparam int CH = 4, DW = 24, IW = 14, SAMPLES = 8192, MAX_PEAKS = 16;
  localparam int PW = $clog2(MAX_PEAKS + 1);
  localparam int S  = (1 << IW) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             run_stb_i = 1'b0;
  logic             valid_i = 1'b0;
  logic [DW-1:0]    thr_i = '0;
  logic [CH*DW-1:0] data_i = '0;
  logic             busy_o, rdy_stb_o;
  logic [CH*IW-1:0] data_o;
  logic [CH*PW-1:0] cnt_o;
  logic [CH-1:0]    ovf_o;

  always #5 clk_i = ~clk_i;

  multi_peak_finder #(.CH(CH), .DW(DW), .IW(IW), .SAMPLES(SAMPLES), .MAX_PEAKS(MAX_PEAKS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_stb_i(run_stb_i), .valid_i(valid_i), .thr_i(thr_i),
    .data_i(data_i), .busy_o(busy_o), .rdy_stb_o(rdy_stb_o), .data_o(data_o), .cnt_o(cnt_o),
    .ovf_o(ovf_o)
  );

  typedef struct { int frame; int ch; int n; int val; int gap; } stim_t;  // gap: idle cycles before n
  typedef struct { int frame; int ch; int slot; int idx; } slot_t;
  typedef struct { int frame; int ch; int cnt; bit ovf; } sum_t;

  stim_t stim_q[$];
  slot_t slot_q[$];
  sum_t  sum_q[$];

  logic [DW-1:0] mem [CH][SAMPLES];
  int            gap_n [SAMPLES];
  int            exp_slot [CH][MAX_PEAKS];
  int            exp_cnt [CH];
  bit            exp_ovf [CH];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"}, busy_o, 0);
    check({tag, " rdy"}, rdy_stb_o, 0);
    check({tag, " data"}, data_o, 0);
    check({tag, " cnt"}, cnt_o, 0);
    check({tag, " ovf"}, ovf_o, 0);
  endtask

  task automatic load_frame(input int f);
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < SAMPLES; i++) mem[c][i] = '0;
      for (int k = 0; k < MAX_PEAKS; k++) exp_slot[c][k] = S;
      exp_cnt[c] = 0;
      exp_ovf[c] = 1'b0;
    end
    for (int i = 0; i < SAMPLES; i++) gap_n[i] = 0;
    foreach (stim_q[i]) if (stim_q[i].frame == f) begin
      mem[stim_q[i].ch][stim_q[i].n] = DW'(stim_q[i].val);
      gap_n[stim_q[i].n] = stim_q[i].gap;
    end
    foreach (slot_q[i]) if (slot_q[i].frame == f) exp_slot[slot_q[i].ch][slot_q[i].slot] = slot_q[i].idx;
    foreach (sum_q[i]) if (sum_q[i].frame == f) begin
      exp_cnt[sum_q[i].ch] = sum_q[i].cnt;
      exp_ovf[sum_q[i].ch] = sum_q[i].ovf;
    end
  endtask

  // Drives run strobe then the frame; abort_n >= 0 hits rst_i mid-cycle before that sample.
  task automatic run_frame(input int abort_n, input int run_pulse_n);
    @(posedge clk_i); #1;
    check("busy before run", busy_o, 0);
    thr_i = 100;
    run_stb_i = 1'b1;
    @(posedge clk_i); #1;
    run_stb_i = 1'b0;
    thr_i = 1000;  // must be ignored: threshold is latched at the run strobe
    check("busy after run", busy_o, 1);
    for (int i = 0; i < SAMPLES; i++) begin
      for (int g = 0; g < gap_n[i]; g++) begin
        valid_i = 1'b0;
        data_i = '1;
        @(posedge clk_i); #1;
      end
      if (i == abort_n) begin
        valid_i = 1'b0;
        data_i = '0;
        check("busy before abort", busy_o, 1);
        #2 rst_i = 1'b1;
        #1 check_quiet("async reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        return;
      end
      valid_i = 1'b1;
      for (int c = 0; c < CH; c++) data_i[c*DW +: DW] = mem[c][i];
      run_stb_i = (i == run_pulse_n);
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    run_stb_i = 1'b0;
    data_i = '0;
  endtask

  // Entered #1 after the edge that took the last sample; run_pulse_k >= 0 pulses run in OUT.
  task automatic check_burst(input int run_pulse_k);
    int stray;
    check("flush cycle rdy", rdy_stb_o, 0);
    check("flush cycle busy", busy_o, 1);
    @(posedge clk_i); #1;
    check("latency 2 cycles", rdy_stb_o, 1);
    for (int k = 0; k < MAX_PEAKS; k++) begin
      check($sformatf("rdy k%0d", k), rdy_stb_o, 1);
      check($sformatf("busy k%0d", k), busy_o, 1);
      for (int c = 0; c < CH; c++) begin
        check($sformatf("slot k%0d ch%0d", k, c), data_o[c*IW +: IW], exp_slot[c][k]);
        check($sformatf("cnt k%0d ch%0d", k, c), cnt_o[c*PW +: PW], exp_cnt[c]);
        check($sformatf("ovf k%0d ch%0d", k, c), ovf_o[c], exp_ovf[c]);
      end
      run_stb_i = (k == run_pulse_k);
      @(posedge clk_i); #1;
    end
    run_stb_i = 1'b0;
    check("end rdy", rdy_stb_o, 0);
    check("end busy", busy_o, 0);
    check("end data", data_o, 0);
    check("end cnt", cnt_o, 0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (busy_o || rdy_stb_o) stray++;
    end
    check("no second frame", stray, 0);
  endtask

  initial begin
    int stray;
    // Frame 0: single peak, plateau across gaps, end-of-frame region, region at n=0.
    stim_q.push_back('{0, 0, 50, 200, 0});
    stim_q.push_back('{0, 0, 51, 300, 0});
    stim_q.push_back('{0, 0, 52, 500, 2});
    stim_q.push_back('{0, 0, 53, 300, 0});
    stim_q.push_back('{0, 0, 54, 200, 0});
    stim_q.push_back('{0, 1, 10, 500, 0});
    stim_q.push_back('{0, 1, 11, 500, 3});
    stim_q.push_back('{0, 2, 8190, 400, 0});
    stim_q.push_back('{0, 2, 8191, 600, 0});
    stim_q.push_back('{0, 3, 0, 150, 0});
    slot_q.push_back('{0, 0, 0, 52});
    slot_q.push_back('{0, 1, 0, 10});
    slot_q.push_back('{0, 2, 0, 8191});
    slot_q.push_back('{0, 3, 0, 0});
    for (int c = 0; c < CH; c++) sum_q.push_back('{0, c, 1, 1'b0});
    // Frame 1: overflow on ch0, tie on ch1, x==thr on ch2, several regions on ch3.
    for (int i = 0; i < 20; i++) stim_q.push_back('{1, 0, 100 * i, 200, 0});
    for (int i = 0; i < 16; i++) slot_q.push_back('{1, 0, i, 100 * i});
    stim_q.push_back('{1, 1, 20, 300, 0});
    stim_q.push_back('{1, 1, 21, 500, 0});
    stim_q.push_back('{1, 1, 22, 500, 0});
    stim_q.push_back('{1, 1, 23, 200, 0});
    stim_q.push_back('{1, 1, 8000, 101, 0});
    stim_q.push_back('{1, 2, 30, 100, 0});
    stim_q.push_back('{1, 3, 5000, 150, 0});
    stim_q.push_back('{1, 3, 5001, 160, 0});
    stim_q.push_back('{1, 3, 5002, 150, 0});
    stim_q.push_back('{1, 3, 6000, 7000, 0});
    stim_q.push_back('{1, 3, 7000, 24'hFFFFFF, 0});
    slot_q.push_back('{1, 1, 0, 21});
    slot_q.push_back('{1, 1, 1, 8000});
    slot_q.push_back('{1, 3, 0, 5001});
    slot_q.push_back('{1, 3, 1, 6000});
    slot_q.push_back('{1, 3, 2, 7000});
    sum_q.push_back('{1, 0, 16, 1'b1});
    sum_q.push_back('{1, 1, 2, 1'b0});
    sum_q.push_back('{1, 2, 0, 1'b0});
    sum_q.push_back('{1, 3, 3, 1'b0});

    #3 check_quiet("in reset");
    #20 rst_i = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (busy_o || rdy_stb_o) stray++;
    end
    check("idle after reset", stray, 0);

    load_frame(0);
    run_frame(-1, 1000);
    check_burst(-1);

    load_frame(1);
    run_frame(-1, -1);
    check_burst(MAX_PEAKS - 1);

    load_frame(0);
    run_frame(4000, -1);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (busy_o || rdy_stb_o) stray++;
    end
    check("no burst after abort", stray, 0);

    load_frame(0);
    run_frame(-1, -1);
    check_burst(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_peak_finder.md
Name: multi_peak_finder

Overview:
- Parametrised successor to the single-run processing block for FBG spectra.
- Takes one frame of SAMPLES spectrum samples on CH parallel channels, each with an optional per-sample valid gap.
- For each channel, finds the index of the maximum inside every contiguous above-threshold region, and stores up to MAX_PEAKS indices per channel.
- After the frame, streams the results out as a burst of MAX_PEAKS strobed words.

Parameters:
- CH, 4, number of parallel channels
- DW, 24, sample width (unsigned)
- IW, 14, index width; requires SAMPLES <= 2^IW - 1
- SAMPLES, 8192, samples per frame
- MAX_PEAKS, 16, peak slots per channel
- Derived: PW = clog2(MAX_PEAKS+1), width of the count output

Ports:
- clk_i, in, 1, system clock
- rst_i, in, 1, asynchronous active-high reset
- run_stb_i, in, 1, one-cycle frame start strobe
- valid_i, in, 1, data_i carries a sample this cycle
- thr_i, in, DW, detection threshold; sampled on the accepted run_stb_i
- data_i, in, CH*DW, channel c at bits [c*DW +: DW]
- busy_o, out, 1, high from the cycle after an accepted run until the end of output
- rdy_stb_o, out, 1, output word valid
- data_o, out, CH*IW, per-channel peak index at [c*IW +: IW]
- cnt_o, out, CH*PW, per-channel number of stored peaks; valid while rdy_stb_o is high
- ovf_o, out, CH, per-channel flag: more than MAX_PEAKS regions were found

Behaviour:
- Reset values: all outputs 0; state IDLE; all peak slots set to the sentinel S = 2^IW-1; counters 0.
- Reset mid-operation: the frame is aborted with no rdy_stb_o. After release, the block waits in IDLE for a new run_stb_i.
- State IDLE:
  - run_stb_i=1 latches thr_i, clears counts, slots and ovf, and moves to ACQ.
  - busy_o rises in the next cycle.
- State ACQ:
  - Each valid_i=1 cycle is sample index n, counting from 0. The first valid sample may arrive in the cycle after run_stb_i.
  - valid_i=0 cycles are ignored and do not advance n.
  - run_stb_i is ignored in every state except IDLE.
- Per-channel region tracking:
  - A sample x > thr is above threshold (strict comparison).
  - When the region is closed and x is above threshold, open a region with max = x, idx = n.
  - While the region is open and x > max, update max = x, idx = n. Ties keep the earlier index.
  - When the region is open and x <= thr, close the region and commit idx.
- Commit:
  - If cnt < MAX_PEAKS, write slot[cnt] = idx and increment cnt.
  - Otherwise, drop the peak and set ovf for that channel (sticky for the frame).
- State FLUSH:
  - Entered in the cycle after the valid sample with n = SAMPLES-1. Lasts one cycle.
  - Any still-open region is committed using the same rules.
  - A region that opens at n = SAMPLES-1 commits index SAMPLES-1.
- State OUT:
  - Lasts exactly MAX_PEAKS consecutive cycles, starting in the cycle after FLUSH.
  - rdy_stb_o is high for all of them.
  - In cycle k, data_o presents slot[k] for every channel; unused slots read S.
  - cnt_o and ovf_o are held constant throughout OUT.
  - Then return to IDLE. busy_o and rdy_stb_o drop in the same cycle; data_o and cnt_o return to 0.
- Latency: the first rdy_stb_o occurs 2 cycles after the last valid sample.
- Channels are fully independent and share only timing.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset check: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately. After release, no rdy_stb_o appears without a run.
- Single peak: thr=100; ch0 = 200,300,500,300,200 at n=50..54, all else 0 -> burst of 16 strobes; ch0 slot0=52, slots1..15=16383, cnt=1; other channels all 16383, cnt=0, ovf=0.
- Plateau and gaps: ch1 = 500,500 at n=10,11 with valid_i low for 3 cycles between them -> ch1 slot0=10. Burst begins exactly 2 cycles after the 8192nd valid sample.
- End of frame: ch2 above threshold at n=8190 (400) and n=8191 (600) -> slot0=8191, committed in FLUSH. Single sample above threshold at n=0 on ch3 -> slot0=0.
- Overflow: ch0 has 20 separate one-sample regions at n=100*i for i=0..19 -> slots = 0,100,…,1500; cnt=16; ovf_o[0]=1.
- Protocol: run_stb_i pulsed during ACQ and during OUT -> ignored, no second frame. Reset at n=4000 -> no burst; a subsequent fresh run completes normally.
